// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: clear control, packed read ports and the two write ports.
// The master modport belongs to the client; the slave modport belongs to the register file.
interface regfile_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_RD     = 2
);
  logic                           clr_req;
  logic                           busy;
  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr;
  logic [NUM_RD*DATA_WIDTH-1:0]   rd_data;
  logic                           wr_en_a;
  logic [ADDR_WIDTH-1:0]          wr_addr_a;
  logic [DATA_WIDTH-1:0]          wr_data_a;
  logic                           wr_en_b;
  logic [ADDR_WIDTH-1:0]          wr_addr_b;
  logic [DATA_WIDTH-1:0]          wr_data_b;
  logic                           wr_collision;

  modport master (
    output clr_req, rd_addr,
    output wr_en_a, wr_addr_a, wr_data_a,
    output wr_en_b, wr_addr_b, wr_data_b,
    input  busy, rd_data, wr_collision
  );

  modport slave (
    input  clr_req, rd_addr,
    input  wr_en_a, wr_addr_a, wr_data_a,
    input  wr_en_b, wr_addr_b, wr_data_b,
    output busy, rd_data, wr_collision
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with optional zero entry, write-to-read bypass
// and a sequential clear engine that sweeps the array after reset or on request.
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int NUM_RD     = 2,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);

  localparam int                  IDX_W     = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(RAM_DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < DEPTH_EXT) && !(ZERO_REG && (a == '0));
  endfunction

  function automatic logic [IDX_W-1:0] idx(input logic [ADDR_WIDTH-1:0] a);
    return a[IDX_W-1:0];
  endfunction

  logic [DATA_WIDTH-1:0]        mem_q [RAM_DEPTH];
  state_t                       state_q;
  logic [ADDR_WIDTH-1:0]        ptr_q;
  logic                         busy_q;
  logic                         collision_q;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data_q;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data_d;

  logic idle;
  logic wr_a_vld;
  logic wr_b_req;
  logic wr_b_vld;
  logic collision_d;

  assign idle        = (state_q == ST_IDLE);
  assign wr_a_vld    = idle && bus.wr_en_a && addr_ok(bus.wr_addr_a);
  assign wr_b_req    = idle && bus.wr_en_b && addr_ok(bus.wr_addr_b);
  // Port A wins a same-address collision; port B is suppressed everywhere, bypass included.
  assign collision_d = wr_a_vld && wr_b_req && (bus.wr_addr_a == bus.wr_addr_b);
  assign wr_b_vld    = wr_b_req && !collision_d;

  always_comb begin
    logic [ADDR_WIDTH-1:0] ra;
    ra        = '0;
    rd_data_d = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (idle && addr_ok(ra)) begin
        if (BYPASS && wr_a_vld && (ra == bus.wr_addr_a)) begin
          rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.wr_data_a;
        end else if (BYPASS && wr_b_vld && (ra == bus.wr_addr_b)) begin
          rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.wr_data_b;
        end else begin
          rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[idx(ra)];
        end
      end
    end
  end

  // Storage has no reset: the clear engine owns the array whenever the FSM is not idle.
  always_ff @(posedge clk) begin
    if (!idle) begin
      mem_q[idx(ptr_q)] <= '0;
    end else begin
      if (wr_a_vld) mem_q[idx(bus.wr_addr_a)] <= bus.wr_data_a;
      if (wr_b_vld) mem_q[idx(bus.wr_addr_b)] <= bus.wr_data_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      ptr_q       <= '0;
      busy_q      <= 1'b1;
      collision_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      collision_q <= collision_d;
      rd_data_q   <= rd_data_d;
      case (state_q)
        ST_CLEAR: begin
          if (ptr_q == LAST_PTR) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        ST_IDLE: begin
          if (bus.clr_req) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_CLEAR;
          ptr_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.wr_collision = collision_q;
  assign bus.rd_data      = rd_data_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a default instance (256 deep, zero entry, bypass) and an
// alternate one (16 deep, no zero entry, no bypass), checked through an expectation queue.
module tb_regfile_mp;

  localparam int SIG_COLL = 8;
  localparam int SIG_BUSY = 9;

  typedef struct {
    bit          dut;
    int          sig;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_RD(2)) d_if ();
  regfile_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_RD(2)) z_if ();

  regfile_mp #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .RAM_DEPTH(256), .NUM_RD(2),
    .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (d_if.slave)
  );

  regfile_mp #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .RAM_DEPTH(16), .NUM_RD(2),
    .ZERO_REG(1'b0), .BYPASS(1'b0)
  ) u_alt (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (z_if.slave)
  );

  function automatic logic [31:0] obs(bit dut, int sig);
    logic [63:0] rd;
    logic        coll;
    logic        bsy;
    if (dut) begin
      rd = z_if.rd_data; coll = z_if.wr_collision; bsy = z_if.busy;
    end else begin
      rd = d_if.rd_data; coll = d_if.wr_collision; bsy = d_if.busy;
    end
    if (sig == SIG_COLL) return {31'b0, coll};
    if (sig == SIG_BUSY) return {31'b0, bsy};
    return rd[sig*32 +: 32];
  endfunction

  task automatic check(string tag, logic [31:0] o, logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, o, e);
    end
  endtask

  task automatic push(bit dut, int sig, logic [31:0] e, string tag);
    exp_t x;
    x.dut = dut; x.sig = sig; x.exp = e; x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic step();
    exp_t x;
    @(posedge clk);
    #1;
    cyc++;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      check(x.tag, obs(x.dut, x.sig), x.exp);
    end
  endtask

  task automatic idle_inputs();
    d_if.clr_req = 1'b0; d_if.rd_addr = '0;
    d_if.wr_en_a = 1'b0; d_if.wr_addr_a = '0; d_if.wr_data_a = '0;
    d_if.wr_en_b = 1'b0; d_if.wr_addr_b = '0; d_if.wr_data_b = '0;
    z_if.clr_req = 1'b0; z_if.rd_addr = '0;
    z_if.wr_en_a = 1'b0; z_if.wr_addr_a = '0; z_if.wr_data_a = '0;
    z_if.wr_en_b = 1'b0; z_if.wr_addr_b = '0; z_if.wr_data_b = '0;
  endtask

  task automatic wr(bit dut, bit port_b, logic [7:0] a, logic [31:0] d);
    if (!dut && !port_b) begin d_if.wr_en_a = 1'b1; d_if.wr_addr_a = a; d_if.wr_data_a = d; end
    if (!dut &&  port_b) begin d_if.wr_en_b = 1'b1; d_if.wr_addr_b = a; d_if.wr_data_b = d; end
    if ( dut && !port_b) begin z_if.wr_en_a = 1'b1; z_if.wr_addr_a = a; z_if.wr_data_a = d; end
    if ( dut &&  port_b) begin z_if.wr_en_b = 1'b1; z_if.wr_addr_b = a; z_if.wr_data_b = d; end
  endtask

  task automatic rd(bit dut, int port, logic [7:0] a, logic [31:0] e, string tag);
    if (dut) z_if.rd_addr[port*8 +: 8] = a;
    else     d_if.rd_addr[port*8 +: 8] = a;
    push(dut, port, e, tag);
  endtask

  initial begin
    int n1;
    int n2;
    int mark;
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", obs(0, SIG_BUSY), 32'd1);
    check("rst_rd0", obs(0, 0), 32'd0);
    check("rst_rd1", obs(0, 1), 32'd0);
    check("rst_coll", obs(0, SIG_COLL), 32'd0);

    // Clear after reset release: 256 cycles for the big array, 16 for the small one
    rst_n = 1'b1;
    n1 = 0; n2 = 0;
    for (int c = 1; c <= 300 && (n1 == 0 || n2 == 0); c++) begin
      step();
      if (!d_if.busy && n1 == 0) n1 = c;
      if (!z_if.busy && n2 == 0) n2 = c;
    end
    check("reset_clear_len_256", n1, 32'd256);
    check("reset_clear_len_16", n2, 32'd16);

    idle_inputs();
    rd(0, 0, 8'd0, 32'd0, "post_clear_a0");
    rd(0, 1, 8'd1, 32'd0, "post_clear_a1");
    step();
    idle_inputs();
    rd(0, 0, 8'd255, 32'd0, "post_clear_a255");
    step();

    // Dual write to distinct addresses
    idle_inputs();
    wr(0, 0, 8'd5, 32'hAAAA_0005);
    wr(0, 1, 8'd9, 32'hBBBB_0009);
    push(0, SIG_COLL, 32'd0, "dual_no_coll");
    step();
    idle_inputs();
    rd(0, 0, 8'd5, 32'hAAAA_0005, "dual_rd5");
    rd(0, 1, 8'd9, 32'hBBBB_0009, "dual_rd9");
    step();

    // Same-address collision: A wins, one-cycle pulse
    idle_inputs();
    wr(0, 0, 8'd7, 32'h11);
    wr(0, 1, 8'd7, 32'h22);
    rd(0, 1, 8'd7, 32'h11, "coll_bypass_a");
    push(0, SIG_COLL, 32'd1, "coll_pulse");
    step();
    idle_inputs();
    rd(0, 0, 8'd7, 32'h11, "coll_keep_a");
    push(0, SIG_COLL, 32'd0, "coll_one_cycle");
    step();

    // Entry 0: hardwired zero on the default instance, ordinary storage on the alternate
    idle_inputs();
    wr(0, 0, 8'd0, 32'hDEAD_BEEF);
    wr(1, 0, 8'd0, 32'hDEAD_BEEF);
    rd(0, 1, 8'd0, 32'd0, "zero_reg_bypass");
    rd(1, 1, 8'd0, 32'd0, "zero_off_prewrite");
    step();
    idle_inputs();
    rd(0, 0, 8'd0, 32'd0, "zero_reg_on");
    rd(1, 0, 8'd0, 32'hDEAD_BEEF, "zero_reg_off");
    step();

    // Bypass on versus off
    idle_inputs();
    wr(0, 0, 8'd3, 32'h1234);
    rd(0, 0, 8'd3, 32'h1234, "bypass_on");
    wr(1, 0, 8'd3, 32'h1234);
    rd(1, 0, 8'd3, 32'd0, "bypass_off_old");
    step();
    idle_inputs();
    rd(0, 0, 8'd3, 32'h1234, "bypass_on_hold");
    rd(1, 0, 8'd3, 32'h1234, "bypass_off_new");
    step();

    // Address boundaries and writes that must not count as collisions
    idle_inputs();
    wr(0, 1, 8'd255, 32'hFFFF_00FF);
    wr(1, 0, 8'd20, 32'hCAFE_0001);
    wr(1, 1, 8'd20, 32'hCAFE_0002);
    push(1, SIG_COLL, 32'd0, "oob_no_coll");
    step();
    idle_inputs();
    wr(0, 0, 8'd0, 32'h1);
    wr(0, 1, 8'd0, 32'h2);
    push(0, SIG_COLL, 32'd0, "zero_no_coll");
    wr(1, 0, 8'd15, 32'h0F0F);
    rd(0, 0, 8'd255, 32'hFFFF_00FF, "last_entry_rd");
    rd(1, 0, 8'd20, 32'd0, "oob_rd_zero");
    step();
    idle_inputs();
    rd(1, 1, 8'd15, 32'h0F0F, "alt_last_entry");
    step();

    // Requested clear: writes and repeat requests during the sweep are ignored
    idle_inputs();
    wr(0, 0, 8'd4, 32'h55);
    step();
    idle_inputs();
    rd(0, 0, 8'd4, 32'h55, "load4");
    d_if.clr_req = 1'b1;
    push(0, SIG_BUSY, 32'd1, "clr_busy");
    step();
    mark = cyc;
    idle_inputs();
    wr(0, 0, 8'd4, 32'h99);
    d_if.clr_req = 1'b1;
    rd(0, 1, 8'd5, 32'd0, "clr_rd_zero");
    push(0, SIG_COLL, 32'd0, "clr_no_coll");
    step();
    idle_inputs();
    for (int c = 0; c < 400 && d_if.busy; c++) step();
    check("clr_req_len", cyc - mark, 32'd256);
    idle_inputs();
    rd(0, 0, 8'd4, 32'd0, "clr_wr_dropped");
    rd(0, 1, 8'd5, 32'd0, "clr_zeroed5");
    step();

    // Async reset in the middle of a clear restarts the sweep
    idle_inputs();
    rd(1, 0, 8'd0, 32'hDEAD_BEEF, "alt_hold0");
    d_if.clr_req = 1'b1;
    step();
    idle_inputs();
    repeat (100) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_alt_busy", obs(1, SIG_BUSY), 32'd1);
    check("async_alt_rd0", obs(1, 0), 32'd0);
    check("async_busy", obs(0, SIG_BUSY), 32'd1);
    repeat (2) step();
    rst_n = 1'b1;
    mark = cyc;
    n2 = 0;
    for (int c = 0; c < 400 && d_if.busy; c++) begin
      step();
      if (!z_if.busy && n2 == 0) n2 = cyc - mark;
    end
    check("restart_clear_len_256", cyc - mark, 32'd256);
    check("restart_clear_len_16", n2, 32'd16);
    idle_inputs();
    rd(0, 0, 8'd4, 32'd0, "post_restart_a4");
    rd(1, 0, 8'd0, 32'd0, "post_restart_alt0");
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-read-port, dual-write-port register file. It replaces the fixed 2R/2W dual-port RAM in datapath and register-file roles.
- Both write ports commit in the same cycle when their addresses differ.
- Optional hardwired-zero entry 0.
- Optional write-to-read bypass.
- Sequential clear engine zeroes the array after reset or on request.

Parameters:
DATA_WIDTH, 32, bits per entry
ADDR_WIDTH, 8, address width of every port
RAM_DEPTH, 1<<ADDR_WIDTH, number of entries (may be less than 2^ADDR_WIDTH)
NUM_RD, 2, number of read ports (1..8)
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
clr_req  in  1  single-cycle request to zero the whole array
busy  out  1  high while the clear engine runs
rd_addr  in  NUM_RD*ADDR_WIDTH  packed read addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
rd_data  out  NUM_RD*DATA_WIDTH  packed registered read data, same packing
wr_en_a  in  1  write enable, port A
wr_addr_a  in  ADDR_WIDTH  write address, port A
wr_data_a  in  DATA_WIDTH  write data, port A
wr_en_b  in  1  write enable, port B
wr_addr_b  in  ADDR_WIDTH  write address, port B
wr_data_b  in  DATA_WIDTH  write data, port B
wr_collision  out  1  one-cycle pulse: both ports wrote the same valid address

Behaviour:
- Reset (rst_n low, async):
  - rd_data = 0, wr_collision = 0, busy = 1.
  - FSM enters CLEAR, clear pointer = 0.
  - Array contents are not reset directly; the clear engine zeroes them.
- FSM states:
  - CLEAR:
    - Each cycle: RAM[ptr] <= 0, then ptr++.
    - When ptr == RAM_DEPTH-1 that entry is written and FSM goes to IDLE. busy is low from the next cycle.
    - A clear takes exactly RAM_DEPTH cycles after rst_n rises.
  - IDLE:
    - clr_req = 1 -> CLEAR next cycle, ptr = 0, busy = 1 next cycle.
    - clr_req during CLEAR is ignored; no restart.
- During CLEAR:
  - All writes are dropped.
  - wr_collision stays 0.
  - rd_data is driven to 0 each cycle.
- Writes (IDLE only):
  - A write is valid when wr_en = 1, addr < RAM_DEPTH, and not (ZERO_REG and addr == 0).
  - Invalid writes are silently dropped.
  - Different valid addresses: both commit at the same clock edge.
  - Same valid address: port A data commits, port B is dropped, wr_collision = 1 the next cycle only.
- Reads:
  - Registered; rd_data[i] updates one cycle after rd_addr[i] is presented.
  - ZERO_REG = 1 and addr == 0 -> 0.
  - addr >= RAM_DEPTH -> 0.
  - BYPASS = 1: if a valid write in the same cycle targets rd_addr[i], rd_data[i] <= that write's data (port A on collision).
  - BYPASS = 0: a read returns the pre-write contents.
- Ports are independent; any number of read ports may target the same address.
- rst_n asserted mid-CLEAR or mid-write:
  - Outputs go to reset values immediately.
  - On release, the clear restarts from ptr = 0.

Test Plan:
- Reset release, DEPTH=256: busy stays high for exactly 256 cycles then falls; reading addresses 0, 1, 255 afterwards returns 0.
- Dual write, A: addr 5 <= 0xAAAA0005, B: addr 9 <= 0xBBBB0009 in one cycle -> next-cycle reads of 5/9 on rd ports 0/1 return both values; wr_collision = 0.
- Collision, A and B both write addr 7 (0x11 / 0x22) -> addr 7 reads 0x11; wr_collision high for exactly one cycle.
- ZERO_REG=1: write 0xDEADBEEF to addr 0 -> reads of addr 0 return 0. With ZERO_REG=0 the same read returns 0xDEADBEEF.
- Bypass: write addr 3 <= 0x1234 while rd_addr[0] = 3 in the same cycle. BYPASS=1 -> rd_data[0] = 0x1234 next cycle. BYPASS=0 -> old value 0, then 0x1234 on the following read.
- clr_req after loading addr 4 = 0x55: busy high RAM_DEPTH cycles; a write to addr 4 during CLEAR is dropped; addr 4 reads 0 after busy falls. Repeat with rst_n pulsed mid-clear -> clear restarts, busy high a further 256 cycles.
